// File: rtl/serial_pkg.sv
// serial_pkg: definitions shared by the serial link receiver and transmitter.
//   FRAME_W   - default bits per frame (must match the transmitter)
//   CNT_W_DEF - default width of the completed-frame counter
//   state_t   - receiver FSM states
package serial_pkg;
  localparam int FRAME_W   = 6;
  localparam int CNT_W_DEF = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;
endpackage

// File: rtl/serial_deser.sv
// serial_deser: 1-bit MSB-first serial to WIDTH-bit parallel receiver.
// Ports:
//   clk      - clock, all state on rising edge
//   rst      - synchronous active-high reset
//   sin      - serial data, one bit per cycle, MSB first
//   start    - marks the cycle in which sin carries the frame MSB
//   data_out - last completed word, held until the next completion
//   valid    - one-cycle pulse, data_out just updated
//   busy     - a frame is partially received
//   err      - one-cycle pulse, frame aborted by an early start
//   frames   - saturating count of completed frames
module serial_deser
  import serial_pkg::*;
#(
  parameter int WIDTH = FRAME_W,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sin,
  input  logic             start,
  output logic [WIDTH-1:0] data_out,
  output logic             valid,
  output logic             busy,
  output logic             err,
  output logic [CNT_W-1:0] frames
);

  localparam int CW = $clog2(WIDTH);

  state_t           state;
  logic [WIDTH-1:0] shift;
  logic [CW-1:0]    cnt;

  // Shift register contents once the current bit is appended.
  logic [WIDTH-1:0] shift_nxt;
  assign shift_nxt = {shift[WIDTH-2:0], sin};

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      shift    <= '0;
      cnt      <= '0;
      data_out <= '0;
      valid    <= 1'b0;
      busy     <= 1'b0;
      err      <= 1'b0;
      frames   <= '0;
    end else begin
      valid <= 1'b0;
      err   <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            shift <= {{(WIDTH-1){1'b0}}, sin};
            cnt   <= CW'(1);
            state <= SHIFT;
            busy  <= 1'b1;
          end
        end
        SHIFT: begin
          if (start) begin
            // Early start, even on the LSB edge: drop the partial frame and
            // treat this bit as the MSB of a fresh one.
            err   <= 1'b1;
            shift <= {{(WIDTH-1){1'b0}}, sin};
            cnt   <= CW'(1);
          end else if (cnt == CW'(WIDTH-1)) begin
            data_out <= shift_nxt;
            valid    <= 1'b1;
            if (frames != {CNT_W{1'b1}})
              frames <= frames + 1'b1;
            shift <= shift_nxt;
            cnt   <= '0;
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            shift <= shift_nxt;
            cnt   <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_deser.sv
// tb_serial_deser: directed bench for serial_deser (WIDTH=6, CNT_W=8).
module tb_serial_deser;
  localparam int W = 6;
  localparam int C = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         sin = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] data_out;
  logic         valid, busy, err;
  logic [C-1:0] frames;

  int checks = 0;
  int errors = 0;

  serial_deser #(.WIDTH(W), .CNT_W(C)) dut (
    .clk(clk), .rst(rst), .sin(sin), .start(start),
    .data_out(data_out), .valid(valid), .busy(busy), .err(err), .frames(frames)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, advance past the edge, leave outputs settled.
  task automatic step(input logic s, input logic b);
    start = s;
    sin   = b;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(1'b0, 1'b0);
    rst = 1'b0;
  endtask

  // Send a full frame MSB first; valid must stay low until the last edge.
  task automatic send_frame(input string tag, input logic [W-1:0] w);
    for (int i = W - 1; i >= 0; i--) begin
      step(i == W - 1, w[i]);
      if (i > 0) chk({tag, " valid mid-frame"}, 32'(valid), 0);
    end
  endtask

  initial begin
    int vcnt;
    logic [W-1:0] tx;

    // Reset state
    do_reset();
    chk("rst data_out", 32'(data_out), 0);
    chk("rst valid", 32'(valid), 0);
    chk("rst busy", 32'(busy), 0);
    chk("rst err", 32'(err), 0);
    chk("rst frames", 32'(frames), 0);

    // 1: single frame 101101
    step(1'b1, 1'b1);
    chk("t1 busy after MSB", 32'(busy), 1);
    step(1'b0, 1'b0); step(1'b0, 1'b1); step(1'b0, 1'b1); step(1'b0, 1'b0);
    chk("t1 valid before LSB", 32'(valid), 0);
    step(1'b0, 1'b1);
    chk("t1 valid", 32'(valid), 1);
    chk("t1 data_out", 32'(data_out), 32'h2D);
    chk("t1 frames", 32'(frames), 1);
    chk("t1 err", 32'(err), 0);
    chk("t1 busy", 32'(busy), 0);
    step(1'b0, 1'b1);
    chk("t1 valid one cycle", 32'(valid), 0);
    chk("t1 data held", 32'(data_out), 32'h2D);

    // 2: back-to-back 111000 then 010101
    do_reset();
    send_frame("t2a", 6'b111000);
    chk("t2a valid", 32'(valid), 1);
    chk("t2a data", 32'(data_out), 32'h38);
    step(1'b1, 1'b0);
    chk("t2b busy after gapless start", 32'(busy), 1);
    chk("t2b err on gapless start", 32'(err), 0);
    step(1'b0, 1'b1); step(1'b0, 1'b0); step(1'b0, 1'b1);
    chk("t2b data held", 32'(data_out), 32'h38);
    step(1'b0, 1'b0);
    chk("t2b valid before LSB", 32'(valid), 0);
    step(1'b0, 1'b1);
    chk("t2b valid 6 cycles later", 32'(valid), 1);
    chk("t2b data", 32'(data_out), 32'h15);
    chk("t2 frames", 32'(frames), 2);

    // 3: early start after 3 bits, new frame 000011
    do_reset();
    step(1'b1, 1'b1); step(1'b0, 1'b1); step(1'b0, 1'b1);
    step(1'b1, 1'b0);
    chk("t3 err pulse", 32'(err), 1);
    chk("t3 no valid", 32'(valid), 0);
    chk("t3 busy", 32'(busy), 1);
    step(1'b0, 1'b0);
    chk("t3 err one cycle", 32'(err), 0);
    step(1'b0, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b1);
    chk("t3 no valid for partial", 32'(valid), 0);
    step(1'b0, 1'b1);
    chk("t3 valid", 32'(valid), 1);
    chk("t3 data", 32'(data_out), 32'h03);
    chk("t3 frames", 32'(frames), 1);

    // 3b: start on the LSB edge aborts too
    step(1'b1, 1'b1); step(1'b0, 1'b0); step(1'b0, 1'b1); step(1'b0, 1'b0); step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    chk("t3b err at LSB", 32'(err), 1);
    chk("t3b no valid at LSB", 32'(valid), 0);
    chk("t3b frames unchanged", 32'(frames), 1);
    chk("t3b data unchanged", 32'(data_out), 32'h03);
    step(1'b0, 1'b0); step(1'b0, 1'b1); step(1'b0, 1'b0); step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    chk("t3b restarted frame valid", 32'(valid), 1);
    chk("t3b restarted frame data", 32'(data_out), 32'h2A);

    // 4: reset mid-frame
    do_reset();
    send_frame("t4pre", 6'b101101);
    step(1'b1, 1'b1); step(1'b0, 1'b1); step(1'b0, 1'b0); step(1'b0, 1'b1);
    rst = 1'b1;
    step(1'b0, 1'b1);
    rst = 1'b0;
    chk("t4 data_out", 32'(data_out), 0);
    chk("t4 valid", 32'(valid), 0);
    chk("t4 err", 32'(err), 0);
    chk("t4 busy", 32'(busy), 0);
    chk("t4 frames", 32'(frames), 0);
    step(1'b0, 1'b1);
    chk("t4 idle ignores sin", 32'(busy), 0);
    send_frame("t4", 6'b100001);
    chk("t4 post valid", 32'(valid), 1);
    chk("t4 post data", 32'(data_out), 32'h21);
    chk("t4 post frames", 32'(frames), 1);

    // 5: counter saturation
    do_reset();
    for (int n = 0; n < 255; n++) begin
      tx = W'($urandom_range(0, 63));
      for (int i = W - 1; i >= 0; i--) step(i == W - 1, tx[i]);
    end
    chk("t5 frames 255", 32'(frames), 255);
    tx = 6'b011110;
    for (int i = W - 1; i >= 0; i--) step(i == W - 1, tx[i]);
    chk("t5 frames saturated", 32'(frames), 255);
    chk("t5 valid at saturation", 32'(valid), 1);
    chk("t5 data at saturation", 32'(data_out), 32'h1E);

    // 6: loopback against a behavioural serial formatter
    do_reset();
    tx   = 6'b110010;
    vcnt = 0;
    for (int i = W - 1; i >= 0; i--) begin
      step(i == W - 1, tx[i]);
      if (valid) vcnt++;
    end
    chk("t6 data", 32'(data_out), 32'h32);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0);
      if (valid) vcnt++;
    end
    chk("t6 valid once", 32'(vcnt), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
